// File: rtl/free_list_pkg.sv
`default_nettype none
// ============================================================================
// Module : free_list_pkg
// Brief  : Shared sizes and types for the physical-register free list.
// Rev    : 1.0
// ============================================================================
package free_list_pkg;

    localparam int PHY_REG_NUM  = 64;
    localparam int ARCH_REG_NUM = 32;
    localparam int FL_NUM       = PHY_REG_NUM - ARCH_REG_NUM;
    localparam int FL_SEL       = $clog2(FL_NUM);
    localparam int PHY_REG_SEL  = $clog2(PHY_REG_NUM);
    localparam int CKPT_NUM     = 4;
    localparam int CKPT_SEL     = $clog2(CKPT_NUM);

    typedef logic [PHY_REG_SEL-1:0] tag_t;
    typedef logic [FL_SEL:0]        ptr_t;
    typedef logic [FL_SEL-1:0]      idx_t;
    typedef logic [1:0]             num_t;
    typedef logic [CKPT_SEL-1:0]    ckpt_id_t;

    function automatic num_t count2(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/free_list_if.sv
`default_nettype none
// ============================================================================
// Module : free_list_if
// Brief  : Rename/commit-side bundle of the free list (FREELIST_CKPT_EN adds
//          the checkpoint/recovery signals).
// Rev    : 1.0
// ============================================================================
interface free_list_if;
    import free_list_pkg::*;

    logic     alloc_req_1;
    logic     alloc_req_2;
    logic     stall_DP;
    tag_t     alloc_tag_1;
    tag_t     alloc_tag_2;
    logic     alloc_ready;
    logic     rel_valid_1;
    logic     rel_valid_2;
    tag_t     rel_tag_1;
    tag_t     rel_tag_2;
    ptr_t     free_count;
    logic     overflow_err;
`ifdef FREELIST_CKPT_EN
    logic     ckpt_take;
    ckpt_id_t ckpt_id;
    logic     prmiss;
    ckpt_id_t prmiss_ckpt_id;
`endif

    modport master (
        output alloc_req_1, alloc_req_2, stall_DP,
        output rel_valid_1, rel_valid_2, rel_tag_1, rel_tag_2,
`ifdef FREELIST_CKPT_EN
        output ckpt_take, ckpt_id, prmiss, prmiss_ckpt_id,
`endif
        input  alloc_tag_1, alloc_tag_2, alloc_ready, free_count, overflow_err
    );

    modport slave (
        input  alloc_req_1, alloc_req_2, stall_DP,
        input  rel_valid_1, rel_valid_2, rel_tag_1, rel_tag_2,
`ifdef FREELIST_CKPT_EN
        input  ckpt_take, ckpt_id, prmiss, prmiss_ckpt_id,
`endif
        output alloc_tag_1, alloc_tag_2, alloc_ready, free_count, overflow_err
    );

endinterface
`default_nettype wire

// File: rtl/free_list_ptr_adv.sv
`default_nettype none
// ============================================================================
// Module : fl_ptr_adv
// Brief  : Combinational FIFO pointer advance by 0/1/2, carrying the wrap bit.
// Rev    : 1.0
// ============================================================================
module fl_ptr_adv
    import free_list_pkg::*;
(
    input  wire ptr_t i_ptr,
    input  wire num_t i_inc,
    output ptr_t      o_ptr
);

    // Depth is a power of two, so natural overflow of FL_SEL+1 bits wraps correctly.
    assign o_ptr = i_ptr + ptr_t'(i_inc);

endmodule
`default_nettype wire

// File: rtl/free_list.sv
`default_nettype none
// ============================================================================
// Module : free_list
// Brief  : Circular FIFO of free physical tags, 2 pops / 2 pushes per cycle.
//          Define FREELIST_CKPT_EN for branch checkpoints of the pop pointer.
// Rev    : 1.0
// ============================================================================
module free_list
    import free_list_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  reset,
    free_list_if.slave fl
);

    tag_t r_mem [FL_NUM];
    ptr_t r_head;
    ptr_t r_tail;
    ptr_t r_count;
    logic r_overflow;

    num_t w_popnum;
    num_t w_pop_amt;
    num_t w_pushnum;
    logic w_alloc_ready;
    ptr_t w_head_pop;
    ptr_t w_tail_push;
    ptr_t w_pop_sum;
    ptr_t w_cnt_sum;
    logic w_cnt_ovf;
    logic w_overflow;
    ptr_t w_head_next;
    ptr_t w_count_next;
    idx_t w_head_idx;
    idx_t w_head_idx1;
    idx_t w_tail_idx;
    idx_t w_tail_idx1;
    tag_t w_wdata0;

    assign w_popnum      = count2(fl.alloc_req_1, fl.alloc_req_2);
    assign w_pushnum     = count2(fl.rel_valid_1, fl.rel_valid_2);
    // Readiness looks only at the registered count; same-cycle releases never bypass.
    assign w_alloc_ready = (r_count >= ptr_t'(w_popnum));
    assign w_pop_amt     = (!fl.stall_DP && w_alloc_ready) ? w_popnum : 2'd0;

    fl_ptr_adv u_head_adv (
        .i_ptr (r_head),
        .i_inc (w_pop_amt),
        .o_ptr (w_head_pop)
    );

    fl_ptr_adv u_tail_adv (
        .i_ptr (r_tail),
        .i_inc (w_pushnum),
        .o_ptr (w_tail_push)
    );

    assign w_head_idx  = r_head[FL_SEL-1:0];
    assign w_head_idx1 = w_head_idx + idx_t'(1);
    assign w_tail_idx  = r_tail[FL_SEL-1:0];
    assign w_tail_idx1 = w_tail_idx + idx_t'(1);
    assign w_wdata0    = fl.rel_valid_1 ? fl.rel_tag_1 : fl.rel_tag_2;

    assign w_pop_sum = r_count - ptr_t'(w_pop_amt);
    assign w_cnt_sum = w_pop_sum + ptr_t'(w_pushnum);
    assign w_cnt_ovf = (w_cnt_sum > ptr_t'(FL_NUM));

`ifdef FREELIST_CKPT_EN
    ptr_t r_ckpt_head [CKPT_NUM];
    ptr_t w_head_rst;
    ptr_t w_rec_count;
    ptr_t w_rec_base;

    assign w_head_rst  = r_ckpt_head[fl.prmiss_ckpt_id];
    assign w_rec_count = w_tail_push - w_head_rst;
    assign w_rec_base  = r_tail - w_head_rst;

    always_comb begin
        w_overflow   = w_cnt_ovf;
        w_head_next  = w_head_pop;
        w_count_next = w_cnt_ovf ? w_pop_sum : w_cnt_sum;
        if (fl.prmiss) begin
            w_overflow   = (w_rec_count > ptr_t'(FL_NUM));
            w_head_next  = w_head_rst;
            w_count_next = w_overflow ? w_rec_base : w_rec_count;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < CKPT_NUM; i++) begin
                r_ckpt_head[i] <= '0;
            end
        end else if (fl.ckpt_take && !fl.prmiss) begin
            r_ckpt_head[fl.ckpt_id] <= w_head_pop;
        end
    end
`else
    always_comb begin
        w_overflow   = w_cnt_ovf;
        w_head_next  = w_head_pop;
        w_count_next = w_cnt_ovf ? w_pop_sum : w_cnt_sum;
    end
`endif

    // Tail resets to index 0 with the wrap bit set: the list starts full.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_head     <= '0;
            r_tail     <= ptr_t'(FL_NUM);
            r_count    <= ptr_t'(FL_NUM);
            r_overflow <= 1'b0;
        end else begin
            r_head     <= w_head_next;
            r_tail     <= w_overflow ? r_tail : w_tail_push;
            r_count    <= w_count_next;
            r_overflow <= r_overflow | w_overflow;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < FL_NUM; i++) begin
                r_mem[i] <= tag_t'(ARCH_REG_NUM + i);
            end
        end else if (!w_overflow) begin
            if (fl.rel_valid_1 || fl.rel_valid_2) begin
                r_mem[w_tail_idx] <= w_wdata0;
            end
            if (fl.rel_valid_1 && fl.rel_valid_2) begin
                r_mem[w_tail_idx1] <= fl.rel_tag_2;
            end
        end
    end

    assign fl.alloc_tag_1  = r_mem[w_head_idx];
    assign fl.alloc_tag_2  = r_mem[w_head_idx1];
    assign fl.alloc_ready  = w_alloc_ready;
    assign fl.free_count   = r_count;
    assign fl.overflow_err = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_free_list.sv
`default_nettype none
// ============================================================================
// Module : tb_free_list
// Brief  : Self-checking bench for free_list against a tag-history queue model.
// Rev    : 1.0
// ============================================================================
module tb_free_list;
    import free_list_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    free_list_if fl_if ();

    free_list dut (
        .clk   (clk),
        .reset (reset),
        .fl    (fl_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: every tag ever entering the list, in order; the live list is
    // hist[n_popped .. end]. Checkpoints remember an absolute pop position.
    int hist[$];
    int n_popped;
    bit m_ovf;
    int ck_pos [CKPT_NUM];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int m_size();
        return hist.size() - n_popped;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < FL_NUM; i++) hist.push_back(ARCH_REG_NUM + i);
        n_popped = 0;
        m_ovf    = 1'b0;
        for (int i = 0; i < CKPT_NUM; i++) ck_pos[i] = 0;
    endtask

    task automatic drive_idle();
        fl_if.alloc_req_1 = 1'b0;
        fl_if.alloc_req_2 = 1'b0;
        fl_if.stall_DP    = 1'b0;
        fl_if.rel_valid_1 = 1'b0;
        fl_if.rel_valid_2 = 1'b0;
        fl_if.rel_tag_1   = '0;
        fl_if.rel_tag_2   = '0;
`ifdef FREELIST_CKPT_EN
        fl_if.ckpt_take      = 1'b0;
        fl_if.ckpt_id        = '0;
        fl_if.prmiss         = 1'b0;
        fl_if.prmiss_ckpt_id = '0;
`endif
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    // One cycle: drive, check outputs against the model, advance the model.
    task automatic step(input bit r1, input bit r2, input bit st,
                        input bit v1, input bit v2, input int t1, input int t2,
                        input bit pm = 0, input int pid = 0,
                        input bit ck = 0, input int cid = 0);
        int popnum, pop, newpos, push, sz;
        bit ready;
        fl_if.alloc_req_1 = r1;
        fl_if.alloc_req_2 = r2;
        fl_if.stall_DP    = st;
        fl_if.rel_valid_1 = v1;
        fl_if.rel_valid_2 = v2;
        fl_if.rel_tag_1   = tag_t'(t1);
        fl_if.rel_tag_2   = tag_t'(t2);
`ifdef FREELIST_CKPT_EN
        fl_if.ckpt_take      = ck;
        fl_if.ckpt_id        = ckpt_id_t'(cid);
        fl_if.prmiss         = pm;
        fl_if.prmiss_ckpt_id = ckpt_id_t'(pid);
`endif
        #2;
        sz     = m_size();
        popnum = int'(r1) + int'(r2);
        ready  = (sz >= popnum);
        check_eq("alloc_ready", fl_if.alloc_ready, ready);
        check_eq("free_count", fl_if.free_count, sz);
        check_eq("overflow_err", fl_if.overflow_err, m_ovf);
        if (sz >= 1) check_eq("alloc_tag_1", fl_if.alloc_tag_1, hist[n_popped]);
        if (sz >= 2) check_eq("alloc_tag_2", fl_if.alloc_tag_2, hist[n_popped+1]);

        pop    = (!st && ready) ? popnum : 0;
        newpos = n_popped + pop;
        if (ck && !pm) ck_pos[cid] = newpos;
        if (pm) newpos = ck_pos[pid];
        push = int'(v1) + int'(v2);
        if (hist.size() + push - newpos > FL_NUM) begin
            m_ovf = 1'b1;
        end else begin
            if (v1) hist.push_back(t1);
            if (v2) hist.push_back(t2);
        end
        n_popped = newpos;
        @(posedge clk);
        #1;
    endtask

    task automatic run_random(input int cycles);
        bit r1, r2, v1, v2;
        for (int i = 0; i < cycles; i++) begin
            r1 = bit'($urandom_range(0, 1));
            r2 = r1 & bit'($urandom_range(0, 1));
            v1 = ($urandom_range(0, 2) == 0);
            v2 = ($urandom_range(0, 2) == 0);
            step(r1, r2, ($urandom_range(0, 3) == 0), v1, v2,
                 int'($urandom_range(0, PHY_REG_NUM-1)),
                 int'($urandom_range(0, PHY_REG_NUM-1)));
        end
    endtask

    initial begin
        drive_idle();
        do_reset();

        // Reset state and first two double pops
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        check_eq("second_pair_tag_1", fl_if.alloc_tag_1, 34);
        step(1, 1, 0, 0, 0, 0, 0);
        check_eq("count_after_two_pops", fl_if.free_count, 28);

        // Drain completely, then an unsatisfiable request
        while (m_size() > 0) step(1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 33, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check_eq("released_tag_33", fl_if.alloc_tag_1, 33);
        step(1, 0, 0, 0, 0, 0, 0);

        // Empty list: same-cycle release is not bypassed
        step(1, 0, 0, 1, 0, 40, 0);
        check_eq("tag_40_ready", fl_if.alloc_ready, 1);
        step(1, 0, 0, 0, 0, 0, 0);

        // Slot-2-only release is compacted to the tail
        step(0, 0, 0, 0, 1, 0, 50);
        check_eq("tag_50_head", fl_if.alloc_tag_1, 50);

        // Refill to full, then overflow with a double release
        while (m_size() < FL_NUM) begin
            if (FL_NUM - m_size() >= 2) step(0, 0, 0, 1, 1, 10 + m_size(), 11 + m_size());
            else                        step(0, 0, 0, 1, 0, 10 + m_size(), 0);
        end
        step(0, 0, 0, 1, 1, 7, 8);
        step(0, 0, 0, 0, 0, 0, 0);
        check_eq("overflow_sticky", fl_if.overflow_err, 1);
        step(1, 1, 0, 0, 0, 0, 0);

`ifdef FREELIST_CKPT_EN
        do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 1, 0);
        check_eq("ckpt_restore_tag", fl_if.alloc_tag_1, 32);
        check_eq("ckpt_restore_count", fl_if.free_count, 32);
        step(0, 0, 0, 0, 0, 0, 0);

        do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 5, 0, 1, 0);
        check_eq("ckpt_ovf_count", fl_if.free_count, 32);
        check_eq("ckpt_ovf_flag", fl_if.overflow_err, 1);
        step(0, 0, 0, 0, 0, 0, 0);
`endif

        // Random traffic, with a reset in the middle of activity
        do_reset();
        run_random(1500);
        do_reset();
        step(0, 0, 0, 0, 0, 0, 0);
        run_random(500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
